// File: rtl/rate_pkg.sv
// Shared widths, limits and state types for the front-panel rate selector.
package rate_pkg;

  localparam int unsigned RATE_W = 7;
  localparam logic [RATE_W-1:0] RATE_STEP = 7'd10;
  localparam logic [RATE_W-1:0] RATE_MAX  = 7'd90;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } hold_state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  // Limits are tested before the add/subtract so no illegal value is ever formed.
  function automatic logic [RATE_W-1:0] step_rate(input logic [RATE_W-1:0] r,
                                                  input dir_e d);
    logic [RATE_W-1:0] res;
    res = r;
    if (d == DIR_UP) begin
      if (r < RATE_MAX) res = r + RATE_STEP;
    end else begin
      if (r != '0) res = r - RATE_STEP;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low button; emits a one-cycle press pulse
// on each debounced 1->0 edge once the key has been seen released after reset.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic          armed_q, armed_d;
  logic [1:0]    prime_q, prime_d;

  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    cnt_d     = '0;
    rel_cnt_d = rel_cnt_q;
    armed_d   = armed_q;
    prime_d   = {prime_q[0], 1'b1};

    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = armed_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // A key held through reset must first be seen stably released before it can press.
    if (!armed_q && prime_q[1]) begin
      if (!sync2_q) begin
        rel_cnt_d = '0;
      end else if (rel_cnt_q == CNT_LAST) begin
        armed_d = 1'b1;
      end else begin
        rel_cnt_d = rel_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      cnt_q     <= '0;
      rel_cnt_q <= '0;
      armed_q   <= 1'b0;
      prime_q   <= '0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
      rel_cnt_q <= rel_cnt_d;
      armed_q   <= armed_d;
      prime_q   <= prime_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/rate_select.sv
// Front-panel rate selector: debounced up/down/stop keys step rate_set through
// 0..90 in tens with saturation and hold-to-auto-repeat.
module rate_select
  import rate_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_up_n,
  input  logic              key_down_n,
  input  logic              key_stop_n,
  output logic [RATE_W-1:0] rate_set,
  output logic              rate_chg
);

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic up_level, up_press;
  logic down_level, down_press;
  logic unused_stop_level, stop_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_up_n),
    .level_o (up_level),
    .press_o (up_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_down (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_down_n),
    .level_o (down_level),
    .press_o (down_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_stop (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_stop_n),
    .level_o (unused_stop_level),
    .press_o (stop_press)
  );

  hold_state_e       state_q;
  dir_e              dir_q;
  logic [RCW-1:0]    cnt_q;
  logic [RATE_W-1:0] rate_q;
  logic              chg_q;

  logic [RATE_W-1:0] up_val, down_val, dir_val;
  logic              dir_level;

  always_comb begin
    up_val    = step_rate(rate_q, DIR_UP);
    down_val  = step_rate(rate_q, DIR_DOWN);
    dir_val   = (dir_q == DIR_UP) ? up_val : down_val;
    dir_level = (dir_q == DIR_UP) ? up_level : down_level;
  end

  // Release is checked ahead of counter expiry so no step lands in the release cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      rate_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (stop_press) begin
        rate_q  <= '0;
        chg_q   <= (rate_q != '0);
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (up_press && !down_press) begin
              dir_q   <= DIR_UP;
              rate_q  <= up_val;
              chg_q   <= (up_val != rate_q);
              state_q <= DELAY;
              cnt_q   <= '0;
            end else if (down_press && !up_press) begin
              dir_q   <= DIR_DOWN;
              rate_q  <= down_val;
              chg_q   <= (down_val != rate_q);
              state_q <= DELAY;
              cnt_q   <= '0;
            end
          end
          DELAY: begin
            if (dir_level) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == DELAY_LAST) begin
              rate_q  <= dir_val;
              chg_q   <= (dir_val != rate_q);
              state_q <= REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + RCW'(1);
            end
          end
          REPEAT: begin
            if (dir_level) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == PERIOD_LAST) begin
              rate_q <= dir_val;
              chg_q  <= (dir_val != rate_q);
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + RCW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign rate_set = rate_q;
  assign rate_chg = chg_q;

endmodule

// File: tb/tb_rate_select.sv
// Directed bench for rate_select with short debounce and repeat timings.
module tb_rate_select;
  import rate_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       key_up_n;
  logic       key_down_n;
  logic       key_stop_n;
  logic [6:0] rate_set;
  logic       rate_chg;

  int n_checks;
  int n_fail;
  int chg_cnt;
  int snap;

  rate_select #(
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_up_n  (key_up_n),
    .key_down_n(key_down_n),
    .key_stop_n(key_stop_n),
    .rate_set  (rate_set),
    .rate_chg  (rate_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial chg_cnt = 0;
  always @(negedge clk) if (rate_chg === 1'b1) chg_cnt = chg_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    key_stop_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(12);
  endtask

  task automatic press_up_release();
    key_up_n = 1'b0;
    tick(10);
    key_up_n = 1'b1;
    tick(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_up_n = 1'b0;
    key_down_n = 1'b1;
    key_stop_n = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (rate_set !== 7'd0) begin n_fail++; $display("FAIL reset_rate: got %0d expected 0", rate_set); end
    n_checks++;
    if (rate_chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg: got %0b expected 0", rate_chg); end
    snap = chg_cnt;
    tick(30);
    n_checks++;
    if (rate_set !== 7'd0 || chg_cnt != snap) begin
      n_fail++; $display("FAIL held_through_reset: got rate %0d pulses %0d expected 0 and 0", rate_set, chg_cnt - snap);
    end
    key_up_n = 1'b1;
    tick(12);
    key_up_n = 1'b0;
    tick(7);
    n_checks++;
    if (rate_set !== 7'd10 || rate_chg !== 1'b1) begin
      n_fail++; $display("FAIL repress_after_reset: got rate %0d chg %0b expected 10 and 1", rate_set, rate_chg);
    end
    key_up_n = 1'b1;
    tick(15);
  endtask

  task automatic test_bounce();
    int unsigned pat[6];
    do_reset();
    pat = '{1, 2, 3, 1, 2, 1};
    snap = chg_cnt;
    for (int i = 0; i < 6; i++) begin
      key_up_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(int'(pat[i]));
    end
    key_up_n = 1'b0;
    tick(6);
    n_checks++;
    if (rate_set !== 7'd0 || chg_cnt != snap) begin
      n_fail++; $display("FAIL bounce_early: got rate %0d pulses %0d expected 0 and 0", rate_set, chg_cnt - snap);
    end
    tick(1);
    n_checks++;
    if (rate_set !== 7'd10 || rate_chg !== 1'b1) begin
      n_fail++; $display("FAIL bounce_step: got rate %0d chg %0b expected 10 and 1", rate_set, rate_chg);
    end
    tick(1);
    n_checks++;
    if (rate_chg !== 1'b0) begin n_fail++; $display("FAIL bounce_pulse_width: got %0b expected 0", rate_chg); end
    key_up_n = 1'b1;
    tick(20);
    n_checks++;
    if (dut.state_q !== IDLE || chg_cnt != snap + 1) begin
      n_fail++; $display("FAIL bounce_release: got state %0d pulses %0d expected %0d and 1", dut.state_q, chg_cnt - snap, IDLE);
    end
  endtask

  task automatic test_autorepeat();
    do_reset();
    repeat (7) press_up_release();
    n_checks++;
    if (rate_set !== 7'd70) begin n_fail++; $display("FAIL reach_70: got %0d expected 70", rate_set); end
    snap = chg_cnt;
    key_up_n = 1'b0;
    tick(7);
    n_checks++;
    if (rate_set !== 7'd80 || rate_chg !== 1'b1) begin
      n_fail++; $display("FAIL repeat_t0: got rate %0d chg %0b expected 80 and 1", rate_set, rate_chg);
    end
    tick(19);
    n_checks++;
    if (rate_set !== 7'd80) begin n_fail++; $display("FAIL repeat_before_delay: got %0d expected 80", rate_set); end
    tick(1);
    n_checks++;
    if (rate_set !== 7'd90 || rate_chg !== 1'b1) begin
      n_fail++; $display("FAIL repeat_t20: got rate %0d chg %0b expected 90 and 1", rate_set, rate_chg);
    end
    tick(8);
    n_checks++;
    if (rate_set !== 7'd90 || rate_chg !== 1'b0 || dut.state_q !== REPEAT) begin
      n_fail++; $display("FAIL repeat_t28_sat: got rate %0d chg %0b state %0d expected 90, 0, %0d", rate_set, rate_chg, dut.state_q, REPEAT);
    end
    tick(25);
    n_checks++;
    if (rate_set !== 7'd90 || chg_cnt != snap + 2) begin
      n_fail++; $display("FAIL repeat_pulses: got rate %0d pulses %0d expected 90 and 2", rate_set, chg_cnt - snap);
    end
    key_up_n = 1'b1;
    tick(15);
  endtask

  task automatic test_down_floor();
    do_reset();
    snap = chg_cnt;
    key_down_n = 1'b0;
    tick(7);
    n_checks++;
    if (rate_set !== 7'd0 || rate_chg !== 1'b0 || dut.state_q !== DELAY) begin
      n_fail++; $display("FAIL down_floor: got rate %0d chg %0b state %0d expected 0, 0, %0d", rate_set, rate_chg, dut.state_q, DELAY);
    end
    tick(30);
    n_checks++;
    if (rate_set !== 7'd0 || chg_cnt != snap) begin
      n_fail++; $display("FAIL down_floor_hold: got rate %0d pulses %0d expected 0 and 0", rate_set, chg_cnt - snap);
    end
    key_down_n = 1'b1;
    tick(15);
  endtask

  task automatic test_stop_priority();
    do_reset();
    repeat (6) press_up_release();
    n_checks++;
    if (rate_set !== 7'd60) begin n_fail++; $display("FAIL reach_60: got %0d expected 60", rate_set); end
    snap = chg_cnt;
    key_down_n = 1'b0;
    tick(7);
    n_checks++;
    if (rate_set !== 7'd50 || rate_chg !== 1'b1) begin
      n_fail++; $display("FAIL down_to_50: got rate %0d chg %0b expected 50 and 1", rate_set, rate_chg);
    end
    tick(3);
    key_stop_n = 1'b0;
    key_up_n = 1'b0;
    tick(7);
    n_checks++;
    if (rate_set !== 7'd0 || rate_chg !== 1'b1 || dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL stop_priority: got rate %0d chg %0b state %0d expected 0, 1, %0d", rate_set, rate_chg, dut.state_q, IDLE);
    end
    tick(1);
    n_checks++;
    if (rate_chg !== 1'b0) begin n_fail++; $display("FAIL stop_pulse_width: got %0b expected 0", rate_chg); end
    tick(30);
    n_checks++;
    if (rate_set !== 7'd0 || chg_cnt != snap + 2) begin
      n_fail++; $display("FAIL stop_no_repeat: got rate %0d pulses %0d expected 0 and 2", rate_set, chg_cnt - snap);
    end
    key_stop_n = 1'b1;
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    tick(15);
  endtask

  task automatic test_simultaneous();
    do_reset();
    snap = chg_cnt;
    key_up_n = 1'b0;
    key_down_n = 1'b0;
    tick(15);
    n_checks++;
    if (rate_set !== 7'd0 || chg_cnt != snap || dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL both_pressed: got rate %0d pulses %0d state %0d expected 0, 0, %0d", rate_set, chg_cnt - snap, dut.state_q, IDLE);
    end
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    tick(12);
    key_up_n = 1'b0;
    tick(7);
    n_checks++;
    if (rate_set !== 7'd10 || rate_chg !== 1'b1) begin
      n_fail++; $display("FAIL lone_up_after_both: got rate %0d chg %0b expected 10 and 1", rate_set, rate_chg);
    end
    key_up_n = 1'b1;
    tick(15);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    key_up_n = 1'b0;
    tick(40);
    n_checks++;
    if (rate_set !== 7'd30 || dut.state_q !== REPEAT) begin
      n_fail++; $display("FAIL hold_to_30: got rate %0d state %0d expected 30 and %0d", rate_set, dut.state_q, REPEAT);
    end
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    n_checks++;
    if (rate_set !== 7'd0 || dut.state_q !== IDLE) begin
      n_fail++; $display("FAIL mid_hold_reset: got rate %0d state %0d expected 0 and %0d", rate_set, dut.state_q, IDLE);
    end
    snap = chg_cnt;
    tick(40);
    n_checks++;
    if (rate_set !== 7'd0 || chg_cnt != snap) begin
      n_fail++; $display("FAIL mid_hold_abandon: got rate %0d pulses %0d expected 0 and 0", rate_set, chg_cnt - snap);
    end
    key_up_n = 1'b1;
    tick(15);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    snap = 0;
    rst_n = 1'b0;
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    key_stop_n = 1'b1;
    test_reset();
    test_bounce();
    test_autorepeat();
    test_down_floor();
    test_stop_priority();
    test_simultaneous();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rate_select.md
# rate_select

Front-panel rate selector: the producer of the 7-bit `rate_set` bus that the segment decoder and PWM generator consume. It debounces three active-low push-buttons (up, down, stop) and steps `rate_set` through 0, 10, …, 90 with saturation. Holding up or down auto-repeats. It sits between the board buttons and the PWM/display path, and is the only writer of `rate_set`.

## Interface
Parameters:
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a key change (20 ms at 50 MHz).
- `REPEAT_DELAY`, 25_000_000: hold time before the first auto-repeat step.
- `REPEAT_PERIOD`, 10_000_000: interval between subsequent auto-repeat steps.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `key_up_n`  in  1  raw up button, asynchronous, 0 = pressed.
- `key_down_n`  in  1  raw down button, asynchronous, 0 = pressed.
- `key_stop_n`  in  1  raw stop button, asynchronous, 0 = pressed.
- `rate_set`  out  7  current rate. Always a value in {0, 10, …, 90}.
- `rate_chg`  out  1  one-cycle pulse, asserted in the first cycle `rate_set` holds a new value.

## Operation
- **Per-key conditioning:**
  - 2-FF synchroniser, then debounce.
  - The debounced level updates only after the synchronised level has differed from it for `DEB_CYCLES` consecutive cycles. Any mismatch-free cycle clears the counter.
  - A press event is a debounced 1→0 transition and lasts one cycle.
- **Step rules:**
  - up: `rate_set + 10`, saturating at 90.
  - down: `rate_set − 10`, saturating at 0.
  - A saturated step leaves `rate_set` unchanged and asserts no `rate_chg`.
- **Stop:**
  - A stop press event forces `rate_set` to 0 and returns the FSM to IDLE.
  - It takes priority over any up/down event in the same cycle.
  - `rate_chg` fires only if the value actually changed.
- **Hold FSM** (single instance, latched direction `dir`):
  - IDLE: on an up press event alone, `dir` = up. On a down press event alone, `dir` = down. In either case, step once and go to DELAY with the counter cleared. Up and down press events in the same cycle are both ignored, and the FSM stays in IDLE.
  - DELAY: count to `REPEAT_DELAY`. On expiry, step in `dir` and go to REPEAT. If the `dir` key's debounced level returns to 1, go to IDLE.
  - REPEAT: step in `dir` every `REPEAT_PERIOD` cycles. If the `dir` key is released, go to IDLE.
  - Outside IDLE, press events on the opposite key are discarded. Releasing and re-pressing is required to act on that key.
  - Auto-repeat at saturation keeps the FSM in REPEAT, with no further change and no pulses.
- **Arithmetic:** 7-bit unsigned. Compare against 90 and 0 before adding or subtracting, so no value outside the legal set is ever produced.
- **Reset:**
  - Outputs: `rate_set` = 0, `rate_chg` = 0.
  - Internal state: debounced levels = 1 (released), synchroniser flops = 1, counters = 0, FSM = IDLE.
  - A key held through reset release produces no press event until it is released and pressed again.
  - Reset asserted mid-hold abandons the hold immediately.

## Timing
- Raw edge to debounced edge: 2 synchroniser cycles plus `DEB_CYCLES`.
- Press event to `rate_set` update: 1 cycle, registered. `rate_chg` is registered and aligned with the new value.
- First auto-repeat step: `REPEAT_DELAY` cycles after the initial step. Later steps are spaced exactly `REPEAT_PERIOD` cycles apart.
- Release detection: the FSM leaves DELAY/REPEAT in the cycle after the debounced level rises. No step occurs in that cycle, even if the counter expires in the same cycle as the release.

## Structure
- Package `rate_pkg` holds:
  - `RATE_W` = 7
  - `RATE_STEP` = 10
  - `RATE_MAX` = 90
  - the hold-FSM state enum (IDLE, DELAY, REPEAT)
- Sub-module `key_debounce`, parameterised by `DEB_CYCLES`:
  - in: raw key
  - out: debounced level and a one-cycle press pulse
  - instantiated three times.
- Top level contains the hold FSM, the repeat counter and the rate register.

## Test plan
Bench parameters: `DEB_CYCLES` = 4, `REPEAT_DELAY` = 20, `REPEAT_PERIOD` = 8.
- **Reset:** hold `rst_n` = 0 with `key_up_n` = 0, then release reset → `rate_set` = 0 and `rate_chg` = 0. No step occurs until up is released and pressed again.
- **Bounce:** toggle `key_up_n` with 1–3 cycle glitches, then hold it low → exactly one step to 10, one `rate_chg` pulse, 2+4+1 cycles after the final stable edge.
- **Auto-repeat and saturation:** start at 70 and hold up for 60 cycles → steps at t0, t0+20 and t0+28 (70→80→90), then no change while held. Exactly two pulses.
- **Down at floor:** at 0, press down → `rate_set` stays 0, no `rate_chg`, FSM enters DELAY.
- **Stop priority:** at 50, hold down; press stop and up in the same cycle → `rate_set` = 0 one cycle later, a single pulse, FSM in IDLE.
- **Simultaneous up/down:** press both with edges in the same cycle → no change. Then a lone up press → 10.
